// File: rtl/keyboard_pkg.sv
// keyboard_pkg: keypad geometry and the row/col to key-index mapping shared with the key latch.
package keyboard_pkg;
    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int NUM_KEYS = KEY_ROWS * KEY_COLS;

    function automatic int key_idx(input int row, input int col);
        return row * KEY_COLS + col;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: per-key debounce; needs DEB_SCANS consecutive disagreeing samples to flip state.
module key_debounce
    import keyboard_pkg::*;
#(
    parameter int DEB_SCANS = 5
) (
    input  logic clk,
    input  logic rstn,
    input  logic sample_en,
    input  logic raw,
    output logic state,
    output logic press_pulse
);
    localparam int CW = $clog2(DEB_SCANS + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= '0;
            state       <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sample_en) begin
                if (raw == state) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_SCANS - 1)) begin
                    cnt         <= '0;
                    state       <= ~state;
                    press_pulse <= ~state;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/keyboard_scan.sv
// keyboard_scan: 4x4 keypad column scanner with row synchronizer and per-key debounce.
module keyboard_scan
    import keyboard_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [3:0]          row_in,
    output logic [3:0]          col_out,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_state
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_m, row_s;
    logic          wrap;

    assign wrap = div_cnt == DW'(SCAN_DIV - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
            col_out <= 4'b1110;
            row_m   <= 4'b1111;
            row_s   <= 4'b1111;
        end else begin
            row_m   <= row_in;
            row_s   <= row_m;
            div_cnt <= wrap ? '0 : div_cnt + DW'(1);
            if (wrap) begin
                col_idx <= col_idx + 2'd1;
                col_out <= ~(4'b0001 << (col_idx + 2'd1));
            end
        end
    end

    // The last slot cycle is the sample point: rows have settled well past the sync delay.
    for (genvar r = 0; r < KEY_ROWS; r++) begin : g_row
        for (genvar c = 0; c < KEY_COLS; c++) begin : g_col
            key_debounce #(.DEB_SCANS(DEB_SCANS)) u_deb (
                .clk        (clk),
                .rstn       (rstn),
                .sample_en  (wrap && col_idx == 2'(c)),
                .raw        (~row_s[r]),
                .state      (key_state[key_idx(r, c)]),
                .press_pulse(key_pulse[key_idx(r, c)])
            );
        end
    end
endmodule

// File: tb/tb_keyboard_scan.sv
// tb_keyboard_scan: keypad model plus sample-schedule reference model, directed and random presses.
module tb_keyboard_scan;
    localparam int SD = 8;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  row_in, col_out;
    logic [15:0] key_pulse, key_state;
    logic [15:0] pressed = '0;

    keyboard_scan #(.SCAN_DIV(SD), .DEB_SCANS(DS)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_pulse(key_pulse),
        .key_state(key_state)
    );

    always #5 clk = ~clk;

    // A held key shorts its row low while its column is strobed.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] m_state, m_pulse;
    int          m_cnt[16];
    int          t;
    int          obs_cnt[16];
    int          obs_cyc[16];
    int          s0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 16; k++) begin
            obs_cnt[k] = 0;
            obs_cyc[k] = -1;
        end
    endtask

    task automatic model_reset();
        m_state = '0;
        m_pulse = '0;
        for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        t = 0;
        clear_obs();
    endtask

    task automatic step();
        logic [3:0] ec;
        int c, k;
        ec = ~(4'b0001 << ((t / SD) % 4));
        check("col_out", {28'd0, col_out}, {28'd0, ec});
        check("key_pulse", {16'd0, key_pulse}, {16'd0, m_pulse});
        check("key_state", {16'd0, key_state}, {16'd0, m_state});
        for (k = 0; k < 16; k++) if (key_pulse[k]) begin
            obs_cnt[k]++;
            obs_cyc[k] = t;
        end
        m_pulse = '0;
        if (t % SD == SD - 1) begin
            c = (t / SD) % 4;
            for (int r = 0; r < 4; r++) begin
                k = r * 4 + c;
                if (pressed[k] == m_state[k]) m_cnt[k] = 0;
                else begin
                    m_cnt[k]++;
                    if (m_cnt[k] == DS) begin
                        m_cnt[k]   = 0;
                        m_state[k] = ~m_state[k];
                        if (m_state[k]) m_pulse[k] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic align(input int m);
        while (t % m != 2) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_pulse", {16'd0, key_pulse}, 32'd0);
        check("rst_state", {16'd0, key_state}, 32'd0);
        check("rst_col", {28'd0, col_out}, 32'he);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        t = 0;
        @(negedge clk);
        do_reset();
        run(320);

        @(negedge clk);
        pressed[5] = 1'b1;
        do_reset();
        run(3200);
        check("k5_cyc", obs_cyc[5], 80);
        check("k5_cnt", obs_cnt[5], 1);

        align(8);
        pressed[5] = 1'b0;
        clear_obs();
        run(128);
        check("k5_rel_state", {31'd0, key_state[5]}, 32'd0);
        check("k5_rel_cnt", obs_cnt[5], 0);

        align(32);
        s0 = t;
        clear_obs();
        pressed[10] = 1'b1;
        run(64);
        check("k10_early", obs_cnt[10], 0);
        pressed[10] = 1'b0;
        run(32);
        pressed[10] = 1'b1;
        run(96);
        check("k10_cnt", obs_cnt[10], 1);
        check("k10_cyc", obs_cyc[10], s0 + 182);
        pressed[10] = 1'b0;
        run(128);

        align(32);
        s0 = t;
        clear_obs();
        pressed[0]  = 1'b1;
        pressed[12] = 1'b1;
        run(128);
        check("k0_12_cnt0", obs_cnt[0], 1);
        check("k0_12_cnt12", obs_cnt[12], 1);
        check("k0_12_cyc0", obs_cyc[0], s0 + 70);
        check("k0_12_cyc12", obs_cyc[12], s0 + 70);
        pressed = '0;
        run(128);

        align(32);
        s0 = t;
        clear_obs();
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        run(128);
        check("k0_15_cnt", obs_cnt[0] + obs_cnt[15], 2);
        check("k0_15_gap", obs_cyc[15] - obs_cyc[0], 24);
        pressed = '0;
        run(128);

        align(32);
        clear_obs();
        pressed[3] = 1'b1;
        run(64);
        check("k3_pre", obs_cnt[3], 0);
        do_reset();
        run(128);
        check("k3_cyc", obs_cyc[3], 96);
        check("k3_cnt", obs_cnt[3], 1);
        pressed = '0;
        run(128);

        repeat (150) begin
            align(8);
            pressed ^= 16'($urandom & $urandom & $urandom);
            run($urandom_range(1, 12) * 8);
        end
        pressed = '0;
        run(128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
